demux_4_16_reg: RTL and testbench
=================================

# demux_4_16_reg

- Registered 1-to-4 distributor for 16-bit words; the receiving end of the 4:1 16-bit word mux path.
- Accepts a stream of words over a valid/ready handshake and steers each word into one of four output lanes, either round-robin or by explicit lane select.
- Once all four lanes hold fresh data, presents them as one frame and waits for a consumer acknowledge.
- Used wherever the 4-lane word mux output has to be reassembled into parallel words.

## Interface

Parameters:
- WIDTH, 16, word width of din and each lane output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- din  input  WIDTH  incoming word.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept a word; high exactly when state is FILL.
- mode  input  1  0 = sequential (internal pointer picks lane), 1 = addressed (s0,s1 pick lane).
- s0  input  1  lane select MSB (addressed mode).
- s1  input  1  lane select LSB (addressed mode). Lane index = {s0,s1}: 00→y0, 01→y1, 10→y2, 11→y3.
- y0, y1, y2, y3  output  WIDTH each  lane holding registers.
- lane_mask  output  4  bit i set when lane i has been loaded in the current frame.
- out_valid  output  1  frame complete, lanes stable.
- out_ack  input  1  consumer has taken the frame.
- frame_count  output  8  number of completed frames, modulo 256.

## Operation

- States: FILL, HOLD. Reset state is FILL.
- Reset values:
  - y0..y3 = 0, lane_mask = 0000, out_valid = 0, in_ready = 1.
  - Internal pointer ptr = 0, frame_count = 0.
- Accept: a word is taken on a rising edge where in_valid && in_ready.
  - mode, s0 and s1 are sampled on that same edge.
- FILL, sequential (mode=0): write din to lane ptr, set lane_mask[ptr], then ptr = ptr+1 with wrap 3→0.
- FILL, addressed (mode=1): write din to lane {s0,s1} and set its mask bit. ptr is unchanged.
- Overwrite: writing a lane whose mask bit is already set replaces the data; the mask is unchanged and no error is raised.
- Mode may change between words. The frame completes only when all four mask bits are set, regardless of mix.
- FILL→HOLD: on the accept edge where lane_mask becomes 1111.
  - out_valid←1, in_ready←0.
  - frame_count←frame_count+1, wrapping 255→0.
- HOLD:
  - y0..y3 and lane_mask are frozen.
  - in_valid is ignored; no word is consumed.
  - s0, s1 and mode are ignored.
- HOLD→FILL: on an edge with out_valid && out_ack.
  - out_valid←0, in_ready←1.
  - lane_mask←0000, ptr←0.
  - y0..y3 keep their last values; they are not cleared.
- out_ack in FILL has no effect.
- Reset asserted mid-frame or in HOLD: all state returns to reset values immediately (asynchronous), with no wait for a clock. A partial frame is discarded and frame_count is not incremented.

## Timing

- Lane write latency: y lane updates on the same rising edge that accepts the word, i.e. visible 1 cycle after presentation.
- in_ready and out_valid are registered (state-decoded), with no combinational path from in_valid or out_ack.
- Minimum frame period is 5 cycles: 4 accept edges plus 1 ack edge. An ack in the first HOLD cycle allows a new word on the following edge.
- Fastest case: out_valid is high for exactly one cycle when out_ack is held high.
- Deassertion of rst_n is treated as synchronous to clk by the surrounding design. The first accept can occur on the first rising edge after release.

## Test plan

- Reset: hold rst_n=0 with random inputs → all y=0, lane_mask=0000, out_valid=0, in_ready=1, frame_count=0. Release and check the first edge accepts.
- Sequential frame: mode=0, stream 4,16,32,87 with in_valid on consecutive cycles.
  - After the 4th edge: y0=4, y1=16, y2=32, y3=87, out_valid=1, in_ready=0, frame_count=1.
- Addressed with overwrite: mode=1, write {s0,s1}=11:87, 00:4, 00:5, 10:32, 01:16.
  - out_valid rises only after the 5th word.
  - Result: y0=5, y1=16, y2=32, y3=87.
- Backpressure: in HOLD, drive in_valid=1, din=0xFFFF for 3 cycles → lanes unchanged. Assert out_ack.
  - Next edge: in_ready=1.
  - The following edge accepts 0xFFFF into y0, since ptr was reset to 0.
- Reset mid-fill: load 2 words, then pulse rst_n low between edges → outputs clear immediately, frame_count stays 0. A new 4-word frame then completes normally.
- Counter wrap: run 256 frames with out_ack tied high → frame_count returns to 0. Each out_valid pulse is 1 cycle, with 5-cycle spacing.

Source files
------------

// File: rtl/demux_4_16_reg.sv
// Registered 1-to-4 word distributor: steers a valid/ready word stream into four lanes
// (round-robin or addressed) and presents them as one frame until acknowledged.
module demux_4_16_reg #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       lane_mask,
    output logic             out_valid,
    input  logic             out_ack,
    output logic [7:0]       frame_count
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lane_q [4];
    logic [WIDTH-1:0] lane_d [4];
    logic [3:0]       mask_q, mask_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [7:0]       frame_count_q, frame_count_d;

    logic             accept;
    logic [1:0]       lane_sel;

    assign accept   = in_valid && (state_q == StFill);
    assign lane_sel = mode ? {s0, s1} : ptr_q;

    always_comb begin
        state_d       = state_q;
        lane_d        = lane_q;
        mask_d        = mask_q;
        ptr_d         = ptr_q;
        frame_count_d = frame_count_q;

        unique case (state_q)
            StFill: begin
                if (accept) begin
                    lane_d[lane_sel] = din;
                    mask_d           = mask_q | (4'b0001 << lane_sel);
                    if (!mode) begin
                        ptr_d = ptr_q + 2'd1;
                    end
                    if (mask_d == 4'b1111) begin
                        state_d       = StHold;
                        frame_count_d = frame_count_q + 8'd1;
                    end
                end
            end
            StHold: begin
                // Lanes keep their data across the ack; only the frame bookkeeping clears.
                if (out_ack) begin
                    state_d = StFill;
                    mask_d  = 4'b0000;
                    ptr_d   = 2'd0;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StFill;
            lane_q        <= '{default: '0};
            mask_q        <= 4'b0000;
            ptr_q         <= 2'd0;
            frame_count_q <= 8'd0;
        end else begin
            state_q       <= state_d;
            lane_q        <= lane_d;
            mask_q        <= mask_d;
            ptr_q         <= ptr_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign in_ready    = (state_q == StFill);
    assign out_valid   = (state_q == StHold);
    assign y0          = lane_q[0];
    assign y1          = lane_q[1];
    assign y2          = lane_q[2];
    assign y3          = lane_q[3];
    assign lane_mask   = mask_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_demux_4_16_reg.sv
// Bench for demux_4_16_reg: a lane/frame model checked every cycle, plus directed
// literal expectations for reset, sequential, addressed, backpressure and wrap cases.
module tb_demux_4_16_reg;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic        in_valid;
    logic        in_ready;
    logic        mode;
    logic        s0;
    logic        s1;
    logic [15:0] y0, y1, y2, y3;
    logic [3:0]  lane_mask;
    logic        out_valid;
    logic        out_ack;
    logic [7:0]  frame_count;

    int checks = 0;
    int errors = 0;

    demux_4_16_reg #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mode       (mode),
        .s0         (s0),
        .s1         (s1),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .lane_mask  (lane_mask),
        .out_valid  (out_valid),
        .out_ack    (out_ack),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: lane contents, which lanes are loaded, next round-robin lane, frame state.
    int m_lane [4];
    bit m_loaded [4];
    int m_next;
    bit m_hold;
    int m_frames;

    always @(posedge clk or negedge rst_n) begin : model
        int  l;
        bit  all;
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                m_lane[i]   <= 0;
                m_loaded[i] <= 1'b0;
            end
            m_next   <= 0;
            m_hold   <= 1'b0;
            m_frames <= 0;
        end else if (!m_hold) begin
            if (in_valid) begin
                l   = mode ? (2 * int'(s0) + int'(s1)) : m_next;
                all = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    if (i != l && !m_loaded[i]) all = 1'b0;
                end
                m_lane[l]   <= int'(din);
                m_loaded[l] <= 1'b1;
                if (!mode) m_next <= (m_next + 1) % 4;
                if (all) begin
                    m_hold   <= 1'b1;
                    m_frames <= (m_frames + 1) % 256;
                end
            end
        end else if (out_ack) begin
            m_hold <= 1'b0;
            m_next <= 0;
            for (int i = 0; i < 4; i++) m_loaded[i] <= 1'b0;
        end
    end

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        int mask;
        mask = 0;
        for (int i = 0; i < 4; i++) if (m_loaded[i]) mask |= (1 << i);
        cmp("model_y0", int'(y0), m_lane[0]);
        cmp("model_y1", int'(y1), m_lane[1]);
        cmp("model_y2", int'(y2), m_lane[2]);
        cmp("model_y3", int'(y3), m_lane[3]);
        cmp("model_lane_mask", int'(lane_mask), mask);
        cmp("model_out_valid", int'(out_valid), int'(m_hold));
        cmp("model_in_ready", int'(in_ready), int'(!m_hold));
        cmp("model_frame_count", int'(frame_count), m_frames);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input logic [15:0] d, input logic m, input logic [1:0] sel);
        din      = d;
        mode     = m;
        s0       = sel[1];
        s1       = sel[0];
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic lanes(input string name, input int e0, input int e1, input int e2,
                         input int e3);
        cmp({name, "_y0"}, int'(y0), e0);
        cmp({name, "_y1"}, int'(y1), e1);
        cmp({name, "_y2"}, int'(y2), e2);
        cmp({name, "_y3"}, int'(y3), e3);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n    = 1'b0;
        din      = 16'h0;
        in_valid = 1'b0;
        mode     = 1'b0;
        s0       = 1'b0;
        s1       = 1'b0;
        out_ack  = 1'b0;

        // Reset with random inputs toggling.
        for (int i = 0; i < 4; i++) begin
            din      = 16'($urandom);
            in_valid = 1'($urandom);
            mode     = 1'($urandom);
            s0       = 1'($urandom);
            s1       = 1'($urandom);
            out_ack  = 1'($urandom);
            step();
        end
        lanes("reset", 0, 0, 0, 0);
        cmp("reset_lane_mask", int'(lane_mask), 0);
        cmp("reset_out_valid", int'(out_valid), 0);
        cmp("reset_in_ready", int'(in_ready), 1);
        cmp("reset_frame_count", int'(frame_count), 0);
        in_valid = 1'b0;
        out_ack  = 1'b0;
        rst_n    = 1'b1;

        // Sequential frame; the first edge after release accepts.
        word(16'd4, 1'b0, 2'b00);
        cmp("first_accept_y0", int'(y0), 4);
        cmp("first_accept_mask", int'(lane_mask), 1);
        word(16'd16, 1'b0, 2'b11);
        word(16'd32, 1'b0, 2'b00);
        cmp("seq_not_done", int'(out_valid), 0);
        word(16'd87, 1'b0, 2'b01);
        lanes("seq", 4, 16, 32, 87);
        cmp("seq_out_valid", int'(out_valid), 1);
        cmp("seq_in_ready", int'(in_ready), 0);
        cmp("seq_frame_count", int'(frame_count), 1);

        // Backpressure in HOLD.
        din      = 16'hFFFF;
        in_valid = 1'b1;
        mode     = 1'b1;
        for (int i = 0; i < 3; i++) step();
        lanes("hold", 4, 16, 32, 87);
        cmp("hold_mask", int'(lane_mask), 15);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;
        cmp("ack_in_ready", int'(in_ready), 1);
        cmp("ack_out_valid", int'(out_valid), 0);
        cmp("ack_mask_clear", int'(lane_mask), 0);
        mode = 1'b0;
        step();
        in_valid = 1'b0;
        cmp("after_ack_y0", int'(y0), 16'hFFFF);
        cmp("after_ack_y1_kept", int'(y1), 16);
        word(16'd1, 1'b0, 2'b00);
        word(16'd2, 1'b0, 2'b00);
        word(16'd3, 1'b0, 2'b00);
        cmp("frame2_count", int'(frame_count), 2);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;

        // Addressed with overwrite.
        word(16'd87, 1'b1, 2'b11);
        word(16'd4, 1'b1, 2'b00);
        word(16'd5, 1'b1, 2'b00);
        word(16'd32, 1'b1, 2'b10);
        cmp("addr_overwrite_no_frame", int'(out_valid), 0);
        cmp("addr_overwrite_mask", int'(lane_mask), 4'b1101);
        word(16'd16, 1'b1, 2'b01);
        cmp("addr_out_valid", int'(out_valid), 1);
        lanes("addr", 5, 16, 32, 87);
        cmp("addr_frame_count", int'(frame_count), 3);
        out_ack = 1'b1;
        step();
        out_ack = 1'b0;

        // Reset mid-fill, between edges.
        word(16'h1111, 1'b0, 2'b00);
        word(16'h2222, 1'b0, 2'b00);
        #2 rst_n = 1'b0;
        #1;
        lanes("midreset", 0, 0, 0, 0);
        cmp("midreset_mask", int'(lane_mask), 0);
        cmp("midreset_in_ready", int'(in_ready), 1);
        cmp("midreset_frame_count", int'(frame_count), 0);
        #1 rst_n = 1'b1;
        word(16'hA0, 1'b0, 2'b00);
        word(16'hA1, 1'b0, 2'b00);
        word(16'hA2, 1'b0, 2'b00);
        word(16'hA3, 1'b0, 2'b00);
        lanes("post_reset", 16'hA0, 16'hA1, 16'hA2, 16'hA3);
        cmp("post_reset_frame_count", int'(frame_count), 1);
        out_ack = 1'b1;
        step();

        // Counter wrap: fresh reset, then 256 back-to-back frames with ack tied high.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        mode     = 1'b0;
        for (int f = 0; f < 256; f++) begin
            for (int w = 0; w < 4; w++) begin
                din = 16'(f * 4 + w);
                step();
                if (w < 3 && f < 2) cmp("wrap_no_early_valid", int'(out_valid), 0);
            end
            cmp("wrap_valid_pulse", int'(out_valid), 1);
            if (f == 254) cmp("wrap_count_255", int'(frame_count), 255);
            step();
            cmp("wrap_valid_one_cycle", int'(out_valid), 0);
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;
        cmp("wrap_count_0", int'(frame_count), 0);
        lanes("wrap_last", 1020, 1021, 1022, 1023);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
